// File: rtl/data_path.sv
// 8-bit CPU datapath: PC, MAR, IR, A, B, CCR, the to/from buses and the ALU.
// Executes the per-cycle load/select strobes issued by control_unit.
module data_path #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       IR_LOAD,
    input  logic       MAR_LOAD,
    input  logic       PC_LOAD,
    input  logic       PC_INC,
    input  logic       A_LOAD,
    input  logic       B_LOAD,
    input  logic       CCR_LOAD,
    input  logic [2:0] ALU_SEL,
    input  logic [1:0] TO_MEMORY_BUS_SEL,
    input  logic [1:0] FROM_MEMORY_BUS_SEL,
    input  logic [7:0] from_memory,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic [7:0] IR,
    output logic [3:0] CCR
);

    logic [7:0] pc_r;
    logic [7:0] mar_r;
    logic [7:0] ir_r;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [3:0] ccr_r;

    logic [7:0] to_bus_s;
    logic [7:0] from_bus_s;
    logic [7:0] op_x_s;
    logic [7:0] op_y_s;
    logic       is_sub_s;
    logic       is_logic_s;
    logic [8:0] sum_s;
    logic [8:0] diff_s;
    logic [7:0] alu_result_s;
    logic       alu_carry_s;
    logic [3:0] alu_flags_s;

    // {N,Z,V,C}; V compares sign bits against the first operand (minuend for sub-type)
    function automatic logic [3:0] calc_flags(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [7:0] r,
        input logic       cy,
        input logic       sub,
        input logic       logic_op
    );
        logic n;
        logic z;
        logic v;
        logic c;
        n = r[7];
        z = (r == 8'h00);
        if (logic_op) begin
            v = 1'b0;
            c = 1'b0;
        end else if (sub) begin
            v = (x[7] != y[7]) && (r[7] != x[7]);
            c = cy;
        end else begin
            v = (x[7] == y[7]) && (r[7] != x[7]);
            c = cy;
        end
        return {n, z, v, c};
    endfunction

    // Source mux for the bus that feeds memory write data
    always_comb begin
        to_bus_s = 8'h00;
        case (TO_MEMORY_BUS_SEL)
            2'b00:   to_bus_s = pc_r;
            2'b01:   to_bus_s = a_r;
            2'b10:   to_bus_s = b_r;
            2'b11:   to_bus_s = 8'h00;
            default: to_bus_s = 8'h00;
        endcase
    end

    // Source mux for the bus that feeds every register load
    always_comb begin
        from_bus_s = 8'h00;
        case (FROM_MEMORY_BUS_SEL)
            2'b00:   from_bus_s = alu_result_s;
            2'b01:   from_bus_s = to_bus_s;
            2'b10:   from_bus_s = from_memory;
            2'b11:   from_bus_s = 8'h00;
            default: from_bus_s = 8'h00;
        endcase
    end

    // ALU operand selection: INC/DEC reuse the adder/subtractor with a constant 1
    always_comb begin
        op_x_s     = a_r;
        op_y_s     = b_r;
        is_sub_s   = 1'b0;
        is_logic_s = 1'b0;
        case (ALU_SEL)
            3'b000: begin op_x_s = a_r; op_y_s = b_r;   end
            3'b001: begin op_x_s = a_r; op_y_s = b_r;   is_sub_s = 1'b1; end
            3'b010: begin op_x_s = a_r; op_y_s = b_r;   is_logic_s = 1'b1; end
            3'b011: begin op_x_s = a_r; op_y_s = b_r;   is_logic_s = 1'b1; end
            3'b100: begin op_x_s = a_r; op_y_s = 8'h01; end
            3'b101: begin op_x_s = b_r; op_y_s = 8'h01; end
            3'b110: begin op_x_s = a_r; op_y_s = 8'h01; is_sub_s = 1'b1; end
            3'b111: begin op_x_s = b_r; op_y_s = 8'h01; is_sub_s = 1'b1; end
            default: begin op_x_s = a_r; op_y_s = b_r;  end
        endcase
    end

    assign sum_s  = {1'b0, op_x_s} + {1'b0, op_y_s};
    assign diff_s = {1'b0, op_x_s} - {1'b0, op_y_s};

    // ALU result and carry/borrow; diff bit 8 is set exactly when x < y unsigned
    always_comb begin
        alu_result_s = 8'h00;
        alu_carry_s  = 1'b0;
        if (is_logic_s) begin
            if (ALU_SEL[0]) begin
                alu_result_s = a_r | b_r;
            end else begin
                alu_result_s = a_r & b_r;
            end
        end else if (is_sub_s) begin
            alu_result_s = diff_s[7:0];
            alu_carry_s  = diff_s[8];
        end else begin
            alu_result_s = sum_s[7:0];
            alu_carry_s  = sum_s[8];
        end
    end

    assign alu_flags_s = calc_flags(op_x_s, op_y_s, alu_result_s, alu_carry_s,
                                    is_sub_s, is_logic_s);

    // Program counter: branch load beats increment, increment wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (PC_LOAD) begin
            pc_r <= from_bus_s;
        end else if (PC_INC) begin
            pc_r <= pc_r + 8'h01;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Datapath registers, each loading the shared from_bus value on its strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mar_r <= 8'h00;
            ir_r  <= 8'h00;
            a_r   <= 8'h00;
            b_r   <= 8'h00;
        end else begin
            if (MAR_LOAD) mar_r <= from_bus_s;
            if (IR_LOAD)  ir_r  <= from_bus_s;
            if (A_LOAD)   a_r   <= from_bus_s;
            if (B_LOAD)   b_r   <= from_bus_s;
        end
    end

    // Condition codes capture this cycle's ALU flags on request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccr_r <= 4'h0;
        end else if (CCR_LOAD) begin
            ccr_r <= alu_flags_s;
        end else begin
            ccr_r <= ccr_r;
        end
    end

    assign address   = mar_r;
    assign to_memory = to_bus_s;
    assign IR        = ir_r;
    assign CCR       = ccr_r;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path with a synchronous-read memory model.
module tb_data_path;

    logic       clk;
    logic       reset;
    logic       IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD;
    logic [2:0] ALU_SEL;
    logic [1:0] TO_MEMORY_BUS_SEL, FROM_MEMORY_BUS_SEL;
    logic [7:0] from_memory;
    logic [7:0] address, to_memory, IR;
    logic [3:0] CCR;

    logic [7:0] mem [0:255];
    logic [7:0] mem_q;
    logic       ovr_en;
    logic [7:0] ovr_val;
    int         total;
    int         bad;

    data_path #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset),
        .IR_LOAD(IR_LOAD), .MAR_LOAD(MAR_LOAD), .PC_LOAD(PC_LOAD), .PC_INC(PC_INC),
        .A_LOAD(A_LOAD), .B_LOAD(B_LOAD), .CCR_LOAD(CCR_LOAD),
        .ALU_SEL(ALU_SEL), .TO_MEMORY_BUS_SEL(TO_MEMORY_BUS_SEL),
        .FROM_MEMORY_BUS_SEL(FROM_MEMORY_BUS_SEL), .from_memory(from_memory),
        .address(address), .to_memory(to_memory), .IR(IR), .CCR(CCR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read data appears one cycle after the address
    always @(posedge clk) mem_q <= mem[address];
    assign from_memory = ovr_en ? ovr_val : mem_q;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        IR_LOAD = 1'b0; MAR_LOAD = 1'b0; PC_LOAD = 1'b0; PC_INC = 1'b0;
        A_LOAD = 1'b0; B_LOAD = 1'b0; CCR_LOAD = 1'b0;
        ALU_SEL = 3'b000; TO_MEMORY_BUS_SEL = 2'b00; FROM_MEMORY_BUS_SEL = 2'b00;
        ovr_en = 1'b0;
    endtask

    // Load chosen registers with v through the from_memory path
    task automatic load_ext(input logic [7:0] v, input logic la, input logic lb, input logic lpc);
        ovr_en = 1'b1; ovr_val = v; FROM_MEMORY_BUS_SEL = 2'b10;
        A_LOAD = la; B_LOAD = lb; PC_LOAD = lpc;
        tick();
        idle();
    endtask

    task automatic peek(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        TO_MEMORY_BUS_SEL = sel;
        #1;
        check_val(tag, to_memory, exp);
        TO_MEMORY_BUS_SEL = 2'b00;
    endtask

    task automatic alu_to_a(input logic [2:0] sel, input string tag,
                            input logic [7:0] exp_r, input logic [3:0] exp_f);
        ALU_SEL = sel; FROM_MEMORY_BUS_SEL = 2'b00; A_LOAD = 1'b1; CCR_LOAD = 1'b1;
        tick();
        idle();
        peek({tag, "_res"}, 2'b01, exp_r);
        check_val({tag, "_ccr"}, {4'h0, CCR}, {4'h0, exp_f});
    endtask

    initial begin
        total = 0; bad = 0;
        ovr_val = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'h10;
        idle();
        reset = 1'b1;
        #3;
        check_val("rst_addr", address, 8'h00);
        check_val("rst_ir", IR, 8'h00);
        check_val("rst_ccr", {4'h0, CCR}, 8'h00);
        peek("rst_pc", 2'b00, 8'h00);
        #8 reset = 1'b0;

        // Populate state, then reset mid-cycle
        load_ext(8'h80, 1'b1, 1'b1, 1'b0);
        ALU_SEL = 3'b000; CCR_LOAD = 1'b1; tick(); idle();
        check_val("pre_ccr", {4'h0, CCR}, 8'h07);
        load_ext(8'h77, 1'b0, 1'b0, 1'b1);
        ovr_en = 1'b1; ovr_val = 8'h99; FROM_MEMORY_BUS_SEL = 2'b10; IR_LOAD = 1'b1; MAR_LOAD = 1'b1;
        tick(); idle();
        check_val("pre_ir", IR, 8'h99);
        #1 reset = 1'b1;
        #1;
        check_val("mid_addr", address, 8'h00);
        check_val("mid_ir", IR, 8'h00);
        check_val("mid_ccr", {4'h0, CCR}, 8'h00);
        peek("mid_pc", 2'b00, 8'h00);
        peek("mid_a", 2'b01, 8'h00);
        peek("mid_b", 2'b10, 8'h00);
        reset = 1'b0;
        PC_INC = 1'b1;
        tick(); tick(); tick();
        idle();
        peek("pc_inc3", 2'b00, 8'h03);

        // Instruction fetch from PC=05
        load_ext(8'h05, 1'b0, 1'b0, 1'b1);
        MAR_LOAD = 1'b1; FROM_MEMORY_BUS_SEL = 2'b01; TO_MEMORY_BUS_SEL = 2'b00; tick(); idle();
        PC_INC = 1'b1; tick(); idle();
        IR_LOAD = 1'b1; FROM_MEMORY_BUS_SEL = 2'b10; tick(); idle();
        check_val("fetch_addr", address, 8'h05);
        check_val("fetch_ir", IR, 8'h10);
        peek("fetch_pc", 2'b00, 8'h06);

        // Arithmetic and flags
        load_ext(8'h7F, 1'b1, 1'b0, 1'b0); load_ext(8'h01, 1'b0, 1'b1, 1'b0);
        alu_to_a(3'b000, "add_ovf", 8'h80, 4'b1010);
        load_ext(8'h00, 1'b1, 1'b0, 1'b0);
        alu_to_a(3'b001, "sub_brw", 8'hFF, 4'b1001);
        load_ext(8'h33, 1'b1, 1'b1, 1'b0);
        alu_to_a(3'b001, "sub_zero", 8'h00, 4'b0100);
        load_ext(8'hF0, 1'b1, 1'b0, 1'b0); load_ext(8'h3C, 1'b0, 1'b1, 1'b0);
        alu_to_a(3'b010, "and", 8'h30, 4'b0000);
        load_ext(8'hF0, 1'b1, 1'b0, 1'b0);
        alu_to_a(3'b011, "or", 8'hFC, 4'b1000);
        load_ext(8'hFF, 1'b1, 1'b0, 1'b0);
        alu_to_a(3'b100, "inca", 8'h00, 4'b0101);
        load_ext(8'h80, 1'b0, 1'b1, 1'b0);
        alu_to_a(3'b111, "decb", 8'h7F, 4'b0010);
        load_ext(8'h7F, 1'b0, 1'b1, 1'b0);
        alu_to_a(3'b101, "incb", 8'h80, 4'b1010);
        load_ext(8'h00, 1'b1, 1'b0, 1'b0);
        alu_to_a(3'b110, "deca", 8'hFF, 4'b1001);

        // PC wrap and load-over-increment priority
        load_ext(8'hFF, 1'b0, 1'b0, 1'b1);
        PC_INC = 1'b1; tick(); idle();
        peek("pc_wrap", 2'b00, 8'h00);
        ovr_en = 1'b1; ovr_val = 8'h40; FROM_MEMORY_BUS_SEL = 2'b10; PC_LOAD = 1'b1; PC_INC = 1'b1;
        tick(); idle();
        peek("pc_prio", 2'b00, 8'h40);

        // MAR from to_bus (B) while B clears via the zero source
        load_ext(8'hC3, 1'b0, 1'b1, 1'b0);
        MAR_LOAD = 1'b1; FROM_MEMORY_BUS_SEL = 2'b01; TO_MEMORY_BUS_SEL = 2'b10; tick(); idle();
        check_val("mar_tobus", address, 8'hC3);
        B_LOAD = 1'b1; FROM_MEMORY_BUS_SEL = 2'b11; tick(); idle();
        peek("b_zero", 2'b10, 8'h00);

        // Store path and hold with no strobes
        load_ext(8'hA5, 1'b1, 1'b0, 1'b0);
        peek("store_a", 2'b01, 8'hA5);
        peek("store_zero", 2'b11, 8'h00);
        tick(); tick();
        peek("hold_a", 2'b01, 8'hA5);
        peek("hold_pc", 2'b00, 8'h40);
        check_val("hold_addr", address, 8'hC3);
        check_val("hold_ir", IR, 8'h10);
        check_val("hold_ccr", {4'h0, CCR}, 8'h09);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
